// File: rtl/spi_master_ctrl_if.sv
// Request/response bus between the CPU-side register file and the SPI master sequencer.
interface spi_master_ctrl_if #(
    parameter int unsigned word_width = 8,
    parameter int unsigned SS_width   = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic [word_width-1:0] req_data;
    logic [SS_width-1:0]   req_ssv;
    logic                  req_se;
    logic                  rsp_valid;
    logic [word_width-1:0] rsp_data;
    logic                  busy;

    // Requester side (register file)
    modport master (
        output req_valid, req_data, req_ssv, req_se,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_data, req_ssv, req_se,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master transaction sequencer: load word, shift N cycles, capture reply, optional idle gap.
module spi_master_ctrl #(
    parameter int unsigned word_width = 8,
    parameter int unsigned send_width = 1,
    parameter int unsigned SS_width   = 2,
    parameter int unsigned gap_cycles = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_master_ctrl_if.slave      host,
    output logic                  spi_SE,
    output logic                  spi_WE,
    output logic                  spi_SSE,
    output logic [SS_width-1:0]   spi_SSV,
    output logic [word_width-1:0] spi_D_IN,
    output logic                  spi_SS_IN,
    input  logic [word_width-1:0] spi_D_OUT
);
    localparam int unsigned N     = word_width / send_width;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned GAP_W = (gap_cycles > 0) ? $clog2(gap_cycles + 1) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] shift_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             handshake;

    assign handshake = (state == IDLE) && host.req_valid;

    // Always a master: the SPI block's slave-select input is tied off
    assign spi_SS_IN = 1'b0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (host.req_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (shift_cnt == CNT_W'(N - 1)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (gap_cycles != 0) begin
                    state_nxt = GAP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(gap_cycles - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift and gap counters; both restart from zero whenever their state is not active
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            shift_cnt <= (state == SHIFT) ? shift_cnt + CNT_W'(1) : '0;
            gap_cnt   <= (state == GAP)   ? gap_cnt + GAP_W'(1)   : '0;
        end
    end

    // Registered controls and status, decoded from the upcoming state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            host.req_ready <= 1'b1;
            host.busy      <= 1'b0;
            spi_WE         <= 1'b0;
            spi_SSE        <= 1'b0;
        end else begin
            host.req_ready <= (state_nxt == IDLE);
            host.busy      <= (state_nxt != IDLE);
            spi_WE         <= (state_nxt == LOAD);
            spi_SSE        <= (state_nxt == SHIFT);
        end
    end

    // Request payload latched at the handshake and held until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_D_IN <= '0;
            spi_SSV  <= '0;
            spi_SE   <= 1'b0;
        end else if (handshake) begin
            spi_D_IN <= host.req_data;
            spi_SSV  <= host.req_ssv;
            spi_SE   <= host.req_se;
        end
    end

    // Capture the received word one cycle after the last shift edge and strobe it out
    always_ff @(posedge clk) begin
        if (rst) begin
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
        end else begin
            host.rsp_valid <= (state == CAPTURE);
            if (state == CAPTURE) begin
                host.rsp_data <= spi_D_OUT;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: two instances (1-bit/gap 1 and 2-bit/gap 0 shifting)
// against a transfer-level timing/data model and a behavioural SPI shift-register peer.
module tb_spi_master_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_ctrl_if #(.word_width(8), .SS_width(2)) hif_a ();
    spi_master_ctrl_if #(.word_width(8), .SS_width(2)) hif_b ();

    // Instance select for stimulus and observation: 0 -> A, 1 -> B
    logic       sel = 1'b0;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data = '0;
    logic [1:0] drv_ssv = '0;
    logic       drv_se = 1'b0;
    logic [7:0] preload = '0;

    assign hif_a.req_valid = drv_valid & ~sel;
    assign hif_a.req_data  = drv_data;
    assign hif_a.req_ssv   = drv_ssv;
    assign hif_a.req_se    = drv_se;
    assign hif_b.req_valid = drv_valid & sel;
    assign hif_b.req_data  = drv_data;
    assign hif_b.req_ssv   = drv_ssv;
    assign hif_b.req_se    = drv_se;

    logic       se_a, we_a, sse_a, ssin_a, se_b, we_b, sse_b, ssin_b;
    logic [1:0] ssv_a, ssv_b;
    logic [7:0] din_a, dout_a, din_b, dout_b;

    spi_master_ctrl #(.word_width(8), .send_width(1), .SS_width(2), .gap_cycles(1)) dut_a (
        .clk(clk), .rst(rst), .host(hif_a),
        .spi_SE(se_a), .spi_WE(we_a), .spi_SSE(sse_a), .spi_SSV(ssv_a),
        .spi_D_IN(din_a), .spi_SS_IN(ssin_a), .spi_D_OUT(dout_a)
    );

    spi_master_ctrl #(.word_width(8), .send_width(2), .SS_width(2), .gap_cycles(0)) dut_b (
        .clk(clk), .rst(rst), .host(hif_b),
        .spi_SE(se_b), .spi_WE(we_b), .spi_SSE(sse_b), .spi_SSV(ssv_b),
        .spi_D_IN(din_b), .spi_SS_IN(ssin_b), .spi_D_OUT(dout_b)
    );

    // Behavioural SPI pair: master shift register (D_OUT) and slave shift register, MSB first
    logic [7:0] mreg_a = '0, sreg_a = '0, mreg_b = '0, sreg_b = '0;
    assign dout_a = mreg_a;
    assign dout_b = mreg_b;

    always @(posedge clk) begin
        if (we_a) begin
            mreg_a <= din_a;
            sreg_a <= preload;
        end else if (sse_a) begin
            mreg_a <= (mreg_a << 1) | (sreg_a >> 7);
            sreg_a <= (sreg_a << 1) | (mreg_a >> 7);
        end
        if (we_b) begin
            mreg_b <= din_b;
            sreg_b <= preload;
        end else if (sse_b) begin
            mreg_b <= (mreg_b << 2) | (sreg_b >> 6);
            sreg_b <= (sreg_b << 2) | (mreg_b >> 6);
        end
    end

    // Pulse counters and length of the most recent SSE burst
    int we_n_a = 0, sse_n_a = 0, run_a = 0, last_run_a = 0;
    int we_n_b = 0, sse_n_b = 0, run_b = 0, last_run_b = 0;
    always @(posedge clk) begin
        if (we_a) we_n_a <= we_n_a + 1;
        if (sse_a) begin
            sse_n_a <= sse_n_a + 1;
            run_a   <= run_a + 1;
        end else begin
            if (run_a != 0) last_run_a <= run_a;
            run_a <= 0;
        end
        if (we_b) we_n_b <= we_n_b + 1;
        if (sse_b) begin
            sse_n_b <= sse_n_b + 1;
            run_b   <= run_b + 1;
        end else begin
            if (run_b != 0) last_run_b <= run_b;
            run_b <= 0;
        end
    end

    // Observation mux for the selected instance
    logic       m_ready, m_busy, m_rsp_valid, m_we, m_sse, m_se, m_ss_in;
    logic [7:0] m_rsp_data, m_din, m_sreg;
    logic [1:0] m_ssv;
    int         m_we_n, m_sse_n, m_last_run;
    always_comb begin
        if (sel) begin
            m_ready = hif_b.req_ready; m_busy = hif_b.busy; m_rsp_valid = hif_b.rsp_valid;
            m_rsp_data = hif_b.rsp_data; m_we = we_b; m_sse = sse_b; m_se = se_b;
            m_ssv = ssv_b; m_ss_in = ssin_b; m_din = din_b; m_sreg = sreg_b;
            m_we_n = we_n_b; m_sse_n = sse_n_b; m_last_run = last_run_b;
        end else begin
            m_ready = hif_a.req_ready; m_busy = hif_a.busy; m_rsp_valid = hif_a.rsp_valid;
            m_rsp_data = hif_a.rsp_data; m_we = we_a; m_sse = sse_a; m_se = se_a;
            m_ssv = ssv_a; m_ss_in = ssin_a; m_din = din_a; m_sreg = sreg_a;
            m_we_n = we_n_a; m_sse_n = sse_n_a; m_last_run = last_run_a;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
        end
    endtask

    // Wait for ready, present one request, return in the cycle after the handshake (LOAD)
    task automatic send_req(input logic [7:0] d, input logic [1:0] ssv, input logic se);
        int k;
        k = 0;
        while (!m_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("req_ready_wait", 32'(k < 200), 32'd1);
        drv_valid = 1'b1;
        drv_data  = d;
        drv_ssv   = ssv;
        drv_se    = se;
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    // Check one transfer cycle by cycle from LOAD (j=1) to the first IDLE cycle.
    // hold_next presents another request from j=4; rst_at>0 asserts reset during cycle t+rst_at.
    task automatic watch(input logic [7:0] d, input logic [1:0] ssv, input logic se,
                         input logic [7:0] pre, input bit hold_next, input logic [7:0] nd,
                         input logic [1:0] nssv, input logic nse, input int rst_at);
        int n, gap, last, we0, sse0;
        n    = sel ? 4 : 8;
        gap  = sel ? 0 : 1;
        last = n + 3 + gap;
        we0  = m_we_n;
        sse0 = m_sse_n;
        for (int j = 1; j <= last; j++) begin
            if (rst_at != 0 && j == rst_at + 1) begin
                check_eq("rst_sse", 32'(m_sse), 32'd0);
                check_eq("rst_busy", 32'(m_busy), 32'd0);
                check_eq("rst_ready", 32'(m_ready), 32'd1);
                check_eq("rst_rsp_data", 32'(m_rsp_data), 32'd0);
                rst = 1'b0;
                for (int k = 0; k < n + 4; k++) begin
                    check_eq("rst_no_rsp", 32'(m_rsp_valid), 32'd0);
                    @(negedge clk);
                end
                return;
            end
            if (hold_next && j == 4) begin
                drv_valid = 1'b1;
                drv_data  = nd;
                drv_ssv   = nssv;
                drv_se    = nse;
            end
            check_eq("we", 32'(m_we), 32'(j == 1));
            check_eq("sse", 32'(m_sse), 32'(j >= 2 && j <= n + 1));
            check_eq("busy", 32'(m_busy), 32'(j <= n + 2 + gap));
            check_eq("ready", 32'(m_ready), 32'(j > n + 2 + gap));
            check_eq("rsp_valid", 32'(m_rsp_valid), 32'(j == n + 3));
            check_eq("ss_in", 32'(m_ss_in), 32'd0);
            check_eq("spi_se", 32'(m_se), 32'(se));
            check_eq("spi_ssv", 32'(m_ssv), 32'(ssv));
            if (j == 1) check_eq("d_in", 32'(m_din), 32'(d));
            if (j == n + 3) begin
                check_eq("rsp_data", 32'(m_rsp_data), 32'(pre));
                check_eq("slave_rx", 32'(m_sreg), 32'(d));
                check_eq("sse_run", 32'(m_last_run), 32'(n));
            end
            if (j == rst_at) rst = 1'b1;
            if (j < last) @(negedge clk);
        end
        check_eq("we_pulses", 32'(m_we_n - we0), 32'd1);
        check_eq("sse_cycles", 32'(m_sse_n - sse0), 32'(n));
    endtask

    task automatic single(input logic [7:0] d, input logic [1:0] ssv, input logic se,
                          input logic [7:0] pre);
        preload = pre;
        send_req(d, ssv, se);
        watch(d, ssv, se, pre, 1'b0, 8'h00, 2'b00, 1'b0, 0);
    endtask

    task automatic check_reset_state();
        check_eq("rst_ready", 32'(m_ready), 32'd1);
        check_eq("rst_busy", 32'(m_busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(m_rsp_data), 32'd0);
        check_eq("rst_we", 32'(m_we), 32'd0);
        check_eq("rst_sse", 32'(m_sse), 32'd0);
        check_eq("rst_se", 32'(m_se), 32'd0);
        check_eq("rst_ssv", 32'(m_ssv), 32'd0);
        check_eq("rst_d_in", 32'(m_din), 32'd0);
        check_eq("rst_ss_in", 32'(m_ss_in), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d, pre;
        logic [1:0] ssv;
        logic       se;

        repeat (3) @(negedge clk);
        sel = 1'b0; #1;
        check_reset_state();
        sel = 1'b1; #1;
        check_reset_state();
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(m_ready), 32'd1);

        // Instance A: 1 bit per edge, one gap cycle
        single(8'hA5, 2'b00, 1'b0, 8'h3C);
        repeat (2) @(negedge clk);
        single(8'h5E, 2'b10, 1'b1, 8'hC7);

        // Back-to-back with the second request held while busy
        preload = 8'h5A;
        send_req(8'h01, 2'b01, 1'b0);
        watch(8'h01, 2'b01, 1'b0, 8'h5A, 1'b1, 8'h80, 2'b10, 1'b1, 0);
        preload = 8'hC3;
        @(negedge clk);
        drv_valid = 1'b0;
        watch(8'h80, 2'b10, 1'b1, 8'hC3, 1'b0, 8'h00, 2'b00, 1'b0, 0);

        // Reset in the middle of SHIFT, then a normal transfer
        preload = 8'h96;
        send_req(8'h69, 2'b11, 1'b1);
        watch(8'h69, 2'b11, 1'b1, 8'h96, 1'b0, 8'h00, 2'b00, 1'b0, 5);
        single(8'hA5, 2'b01, 1'b0, 8'h3C);

        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom); pre = 8'($urandom); ssv = 2'($urandom); se = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            single(d, ssv, se, pre);
        end

        // Instance B: 2 bits per edge, no gap
        sel = 1'b1;
        @(negedge clk);
        single(8'hA5, 2'b00, 1'b0, 8'h3C);
        preload = 8'h11;
        send_req(8'h01, 2'b10, 1'b1);
        watch(8'h01, 2'b10, 1'b1, 8'h11, 1'b1, 8'h80, 2'b01, 1'b0, 0);
        preload = 8'hEE;
        @(negedge clk);
        drv_valid = 1'b0;
        watch(8'h80, 2'b01, 1'b0, 8'hEE, 1'b0, 8'h00, 2'b00, 1'b0, 0);

        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom); pre = 8'($urandom); ssv = 2'($urandom); se = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            single(d, ssv, se, pre);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Transaction sequencer for the `SPI` shift-register block when it acts as bus master. It accepts one word per request over a valid/ready handshake and drives the SPI control pins in order: it loads the word with a one-cycle `WE`, holds `SSE` for exactly `word_width/send_width` shift cycles, then captures `D_OUT` as the received word. It returns that word on a one-cycle response strobe. It sits between a CPU-side I/O register file and a single `SPI` instance, and only one transfer is in flight at a time.

## Interface
Parameters:
- `word_width`, 8, width of one transferred word; must be a multiple of `send_width`.
- `send_width`, 1, bits shifted per `SCLK` edge; identical to the value given to the `SPI` instance.
- `SS_width`, 2, width of the slave-select value forwarded to `SSV`.
- `gap_cycles`, 1, idle cycles enforced after each transfer before `req_ready` re-asserts; 0 is legal.

Ports:
- `clk`  in  1  single clock; also the `SCLK` of the SPI instance. Reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; high only in IDLE.
- `req_data`  in  word_width  word to transmit.
- `req_ssv`  in  SS_width  slave-select value for this transfer.
- `req_se`  in  1  sync edge for this transfer (0 = high, 1 = low).
- `rsp_valid`  out  1  one-cycle strobe: `rsp_data` is valid.
- `rsp_data`  out  word_width  received word.
- `busy`  out  1  high in every state except IDLE.
- `spi_SE`  out  1  to `SPI.SE`.
- `spi_WE`  out  1  to `SPI.WE`.
- `spi_SSE`  out  1  to `SPI.SSE`.
- `spi_SSV`  out  SS_width  to `SPI.SSV`.
- `spi_D_IN`  out  word_width  to `SPI.D_IN`.
- `spi_SS_IN`  out  1  to `SPI.SS_IN`; constant 0 (master).
- `spi_D_OUT`  in  word_width  from `SPI.D_OUT`.

## Operation
- N = `word_width/send_width`. The shift counter width is `$clog2(N+1)`.
- States:
  - IDLE: `req_ready`=1, all SPI controls deasserted. `req_valid` causes a handshake, which latches `req_data`, `req_ssv` and `req_se` into registers and moves to LOAD.
  - LOAD (1 cycle): `spi_WE`=1, `spi_SSE`=0, `spi_D_IN`=latched data. Next state is SHIFT, and the counter is cleared to 0.
  - SHIFT (N cycles): `spi_WE`=0, `spi_SSE`=1. The counter increments each cycle. When the counter reaches N-1, the next state is CAPTURE.
  - CAPTURE (1 cycle): `spi_SSE`=0. `rsp_data` <= `spi_D_OUT` and `rsp_valid` <= 1 (registered). Next state is GAP if `gap_cycles`>0, else IDLE.
  - GAP (`gap_cycles` cycles): all controls deasserted, then IDLE.
- `spi_SE` and `spi_SSV` come from the latched registers. They are stable from LOAD through CAPTURE and hold their last value otherwise.
- `spi_D_IN` is driven from the latched data register at all times; it is only meaningful while `spi_WE`=1.
- A request arriving while `busy`=1 is not accepted and not lost. The requester holds `req_valid` and its payload until `req_ready`.
- `rsp_valid` has no backpressure: the consumer must take `rsp_data` in its strobe cycle. `rsp_data` holds its value until the next capture.
- Reset values: state IDLE, `req_ready`=1 (after reset deasserts), `busy`=0, `rsp_valid`=0, `rsp_data`=0, `spi_WE`=0, `spi_SSE`=0, `spi_SE`=0, `spi_SSV`=0, `spi_D_IN`=0, `spi_SS_IN`=0.
- Reset mid-transfer: on the next edge, force IDLE and clear the counter and all controls. `SSE` drops in the very next cycle, no `rsp_valid` is produced, and the partial word is discarded.

## Timing
- Handshake accepted at cycle t (`req_valid` & `req_ready` at the edge ending t):
  - LOAD at t+1.
  - SHIFT at t+2 … t+N+1.
  - CAPTURE at t+N+2.
  - `rsp_valid` high for exactly cycle t+N+3.
- Total busy time is N+2+`gap_cycles` cycles. `req_ready` returns at t+N+3+`gap_cycles`.
- The next handshake can be accepted in the first IDLE cycle, which gives back-to-back throughput of one word per N+3+`gap_cycles` cycles.
- `spi_SSE` is high for exactly N consecutive cycles per transfer, never more, never fewer.
- `spi_D_OUT` is sampled one cycle after the last shift edge, which covers the SPI output register latency.
- `req_ready` and `busy` are pure state decodes, with no combinational path from `req_valid`.

## Test plan
- Single transfer, `word_width`=8, `send_width`=1, `gap_cycles`=1. Slave model preloaded with 8'h3C, request `req_data`=8'hA5, `req_se`=0 -> slave receives 8'hA5, `rsp_data`=8'h3C with `rsp_valid` at t+11, `spi_SSE` high for exactly 8 cycles.
- `send_width`=2, same data -> `spi_SSE` high for exactly 4 cycles, `rsp_data`=8'h3C at t+7.
- Back-to-back: `req_valid` held with 8'h01 then 8'h80 -> second handshake exactly at t+12. Both responses correct, `spi_WE` pulses exactly once per word.
- Request during busy: assert `req_valid` with 8'hFF at t+4 -> `req_ready` stays 0 until t+12. The word is accepted then, and the first transfer is unaffected.
- Reset asserted at t+5 (mid-SHIFT) -> `spi_SSE`=0 and `busy`=0 from t+6, no `rsp_valid`. A new request after reset completes normally with the correct data.
- `req_se`=1, `req_ssv`=2'b10 -> `spi_SE`=1 and `spi_SSV`=2'b10 are stable from LOAD through CAPTURE, and `spi_SS_IN`=0 throughout.
